amber128_slot_sequencer: RTL and testbench
==========================================

AMBER128_SLOT_SEQUENCER -- requirements
Module: amber128_slot_sequencer

Interface
REQ-001 SHALL have parameter NUM_SLOTS, default 5, number of 24-bit slots per 128-bit bundle.
REQ-002 SHALL have port clk_i  input  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_ni  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port fetch_i  input  amber128_fetch_s  bundle from fetch (valid, word_addr, bundle[127:0]).
REQ-005 SHALL have port fetch_ready_o  output  1  bundle accepted when fetch_i.valid & fetch_ready_o.
REQ-006 SHALL have port flush_i  input  1  branch redirect; discard held bundle.
REQ-007 SHALL have port issue_ready_i  input  1  decode/execute accepts current sub-instruction.
REQ-008 SHALL have port issue_fetch_o  output  amber128_fetch_s  held bundle to decoder; .valid = issue valid.
REQ-009 SHALL have port slot_idx_o  output  3  current slot 0..NUM_SLOTS-1, drives decoder slot_idx_i.
REQ-010 SHALL have port sub12_o  output  1  current 12-bit half, drives decoder sub12_i.
REQ-011 SHALL have port last_o  output  1  current sub-instruction is the last of the bundle.

Function
REQ-012 SHALL hold one bundle in a register; states EMPTY (no bundle) and ISSUE (bundle held).
REQ-013 SHALL decode per-slot pairing from held bundle: two12(s) = bundle[127-s] (flag bit 4-s).
REQ-014 issue_fetch_o.valid SHALL be 1 iff state is ISSUE; other fields equal the held bundle.
REQ-015 accept = issue_fetch_o.valid & issue_ready_i; on accept with two12(slot) & !sub12: sub12<=1, slot unchanged.
REQ-016 on accept otherwise (not last): sub12<=0, slot<=slot+1.
REQ-017 last_o SHALL be 1 when slot==NUM_SLOTS-1 and (!two12(slot) or sub12==1).
REQ-018 fetch_ready_o SHALL equal !flush_i & (state==EMPTY | (accept & last_o)) (combinational).
REQ-019 on accept & last_o: if fetch_i.valid, load new bundle, slot<=0, sub12<=0, stay ISSUE (zero-bubble); else go EMPTY.
REQ-020 in EMPTY with fetch_i.valid & !flush_i: load bundle, slot<=0, sub12<=0, go ISSUE; first issue next cycle.
REQ-021 without accept, slot, sub12 and bundle SHALL hold (stall stable).
REQ-022 flush_i SHALL take priority over accept and load: next state EMPTY, slot<=0, sub12<=0, no bundle loaded that cycle.
REQ-023 slot SHALL never exceed NUM_SLOTS-1; no wrap inside a bundle.
REQ-024 slot/sub12 SHALL be independent of instruction opcode (nops/illegals issued like any other).

Reset
REQ-025 while rst_ni low: state EMPTY, bundle register 0, slot_idx_o=0, sub12_o=0, issue_fetch_o all 0, last_o=0.
REQ-026 reset assertion mid-bundle SHALL discard it immediately (async); first bundle after release loads per REQ-020.

Structure
REQ-027 amber128_fetch_s, C_XLEN and slot count constant (NUM_SLOTS default) SHALL come from amber128_pkg; state enum local.
REQ-028 SHALL be a single module with no sub-modules; amber128_decoder instantiated by parent, not here.

Verification
REQ-029 flags=5'b00000, issue_ready_i=1 -> 5 issues, slot 0..4, sub12 always 0, last_o only on slot 4.
REQ-030 flags=5'b10100 -> 7 issues: (0,0)(0,1)(1,0)(2,0)(2,1)(3,0)(4,0); last_o on (4,0).
REQ-031 flags=5'b00001 with a second bundle valid -> last on (4,1), fetch_ready_o=1 that cycle, next cycle (0,0) of new bundle, no bubble.
REQ-032 issue_ready_i=0 for 3 cycles at slot 2 -> slot_idx_o=2, sub12_o, bundle stable; resumes at slot 3 after ready.
REQ-033 flush_i at slot 3 with fetch_i.valid=1 -> fetch_ready_o=0, next cycle valid=0/EMPTY; following cycle loads, slot 0.
REQ-034 rst_ni low at slot 2 sub12=1 -> outputs zero immediately; after release, new bundle issues from slot 0.

Source files
------------

// File: rtl/amber128_pkg.sv
// Shared types and constants for the amber128 front end: fetch bundle record,
// datapath width, slot count and the per-slot pairing flag lookup.
package amber128_pkg;

  localparam int C_XLEN      = 32;
  localparam int C_NUM_SLOTS = 5;
  localparam int C_BUNDLE_W  = 128;

  typedef struct packed {
    logic                  valid;
    logic [C_XLEN-1:0]     word_addr;
    logic [C_BUNDLE_W-1:0] bundle;
  } amber128_fetch_s;

  // Slot s carries two 12-bit halves when bundle bit 127-s is set.
  function automatic logic slot_two12(input logic [C_BUNDLE_W-1:0] bundle,
                                      input logic [2:0]            slot);
    return bundle[7'd127 - {4'd0, slot}];
  endfunction

endpackage

// File: rtl/amber128_slot_sequencer.sv
// Holds one 128-bit bundle and steps the decoder through its slots and
// 12-bit halves, handing over to the next bundle without a bubble.
module amber128_slot_sequencer
  import amber128_pkg::*;
#(
  parameter int NUM_SLOTS = C_NUM_SLOTS
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  amber128_fetch_s fetch_i,
  output logic            fetch_ready_o,
  input  logic            flush_i,
  input  logic            issue_ready_i,
  output amber128_fetch_s issue_fetch_o,
  output logic [2:0]      slot_idx_o,
  output logic            sub12_o,
  output logic            last_o
);

  typedef enum logic [0:0] {
    ST_EMPTY = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

  localparam logic [2:0] LAST_SLOT = 3'(NUM_SLOTS - 1);

  state_e                state_r;
  logic [C_XLEN-1:0]     addr_r;
  logic [C_BUNDLE_W-1:0] bundle_r;
  logic [2:0]            slot_r;
  logic                  sub12_r;

  logic pair_s;
  logic accept_s;
  logic last_s;
  logic fetch_ready_s;

  // Handshake and end-of-bundle decode from the held state.
  always_comb begin
    pair_s   = slot_two12(bundle_r, slot_r);
    accept_s = (state_r == ST_ISSUE) & issue_ready_i;
    if (state_r == ST_ISSUE) begin
      last_s = (slot_r == LAST_SLOT) & (~pair_s | sub12_r);
    end else begin
      last_s = 1'b0;
    end
    fetch_ready_s = ~flush_i & ((state_r == ST_EMPTY) | (accept_s & last_s));
  end

  // Bundle holding FSM; flush beats both accept and load.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r  <= ST_EMPTY;
      addr_r   <= '0;
      bundle_r <= '0;
      slot_r   <= 3'd0;
      sub12_r  <= 1'b0;
    end else if (flush_i) begin
      state_r  <= ST_EMPTY;
      addr_r   <= '0;
      bundle_r <= '0;
      slot_r   <= 3'd0;
      sub12_r  <= 1'b0;
    end else begin
      case (state_r)
        ST_EMPTY: begin
          if (fetch_i.valid) begin
            state_r  <= ST_ISSUE;
            addr_r   <= fetch_i.word_addr;
            bundle_r <= fetch_i.bundle;
            slot_r   <= 3'd0;
            sub12_r  <= 1'b0;
          end
        end
        ST_ISSUE: begin
          if (accept_s & last_s) begin
            slot_r  <= 3'd0;
            sub12_r <= 1'b0;
            if (fetch_i.valid) begin
              addr_r   <= fetch_i.word_addr;
              bundle_r <= fetch_i.bundle;
            end else begin
              state_r <= ST_EMPTY;
            end
          end else if (accept_s & pair_s & ~sub12_r) begin
            sub12_r <= 1'b1;
          end else if (accept_s) begin
            sub12_r <= 1'b0;
            slot_r  <= slot_r + 3'd1;
          end
        end
        default: begin
          state_r <= ST_EMPTY;
          slot_r  <= 3'd0;
          sub12_r <= 1'b0;
        end
      endcase
    end
  end

  assign issue_fetch_o = '{valid:     (state_r == ST_ISSUE),
                           word_addr: addr_r,
                           bundle:    bundle_r};
  assign slot_idx_o    = slot_r;
  assign sub12_o       = sub12_r;
  assign last_o        = last_s;
  assign fetch_ready_o = fetch_ready_s;

endmodule

// File: tb/tb_amber128_slot_sequencer.sv
// Bench for amber128_slot_sequencer: directed vector table, directed stall,
// flush and reset sequences, then random traffic against an issue-list model.
module tb_amber128_slot_sequencer;
  import amber128_pkg::*;

  logic            clk = 1'b0;
  logic            rst_ni;
  amber128_fetch_s fetch;
  logic            fetch_ready;
  logic            flush;
  logic            issue_ready;
  amber128_fetch_s issue_fetch;
  logic [2:0]      slot_idx;
  logic            sub12;
  logic            last;

  int n_checks = 0;
  int n_fail   = 0;

  amber128_slot_sequencer #(.NUM_SLOTS(5)) dut (
    .clk_i         (clk),
    .rst_ni        (rst_ni),
    .fetch_i       (fetch),
    .fetch_ready_o (fetch_ready),
    .flush_i       (flush),
    .issue_ready_i (issue_ready),
    .issue_fetch_o (issue_fetch),
    .slot_idx_o    (slot_idx),
    .sub12_o       (sub12),
    .last_o        (last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic fv, input logic [127:0] b, input logic [31:0] a,
                       input logic fl, input logic rdy);
    fetch.valid     = fv;
    fetch.bundle    = b;
    fetch.word_addr = a;
    flush           = fl;
    issue_ready     = rdy;
  endtask

  function automatic logic [127:0] mkb(input logic [4:0] flags);
    logic [127:0] b;
    b = {$urandom, $urandom, $urandom, $urandom};
    b[127:123] = flags;
    return b;
  endfunction

  // Reference model: the held bundle is a list of pending issues (slot*2+half).
  logic         m_valid = 1'b0;
  int           m_q[$];
  logic [127:0] m_bundle;
  logic [31:0]  m_addr;

  task automatic mcycle(input logic fv, input logic [127:0] b, input logic [31:0] a,
                        input logic fl, input logic rdy);
    logic exp_fr;
    drive(fv, b, a, fl, rdy);
    #1;
    exp_fr = !fl && (!m_valid || (rdy && m_q.size() == 1));
    chk("valid", 128'(issue_fetch.valid), 128'(m_valid));
    chk("fetch_ready", 128'(fetch_ready), 128'(exp_fr));
    if (m_valid) begin
      chk("slot", 128'(slot_idx), 128'(m_q[0] / 2));
      chk("sub12", 128'(sub12), 128'(m_q[0] % 2));
      chk("last", 128'(last), 128'(m_q.size() == 1));
      chk("bundle", issue_fetch.bundle, m_bundle);
      chk("word_addr", 128'(issue_fetch.word_addr), 128'(m_addr));
    end
    @(posedge clk);
    if (fl) begin
      m_valid = 1'b0;
      m_q.delete();
    end else if (exp_fr && fv) begin
      m_valid  = 1'b1;
      m_bundle = b;
      m_addr   = a;
      m_q.delete();
      for (int s = 0; s < 5; s++) begin
        m_q.push_back(s * 2);
        if (b[127 - s]) m_q.push_back(s * 2 + 1);
      end
    end else if (m_valid && rdy) begin
      void'(m_q.pop_front());
      if (m_q.size() == 0) m_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  typedef struct {
    logic       fv;
    logic [4:0] flags;
    logic       ev;
    logic [2:0] es;
    logic       esub;
    logic       el;
    logic       efr;
  } vec_t;

  vec_t tbl[22];

  function automatic vec_t mkv(input logic fv, input logic [4:0] f, input logic ev,
                               input logic [2:0] s, input logic sb, input logic l,
                               input logic fr);
    vec_t v;
    v.fv = fv; v.flags = f; v.ev = ev; v.es = s; v.esub = sb; v.el = l; v.efr = fr;
    return v;
  endfunction

  initial begin
    rst_ni = 1'b0;
    drive(1'b0, 128'd0, 32'd0, 1'b0, 1'b0);
    #2;
    chk("rst_valid", 128'(issue_fetch.valid), 128'd0);
    chk("rst_slot", 128'(slot_idx), 128'd0);
    chk("rst_sub12", 128'(sub12), 128'd0);
    chk("rst_last", 128'(last), 128'd0);
    chk("rst_bundle", issue_fetch.bundle, 128'd0);
    chk("rst_addr", 128'(issue_fetch.word_addr), 128'd0);
    @(negedge clk);
    @(negedge clk);
    rst_ni = 1'b1;

    // Pairing on slots 0 and 2, then a bundle paired on slot 4 handing over
    // back-to-back to an unpaired bundle.
    tbl[0]  = mkv(1'b1, 5'b10100, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    tbl[1]  = mkv(1'b0, 5'b00000, 1'b1, 3'd0, 1'b0, 1'b0, 1'b0);
    tbl[2]  = mkv(1'b0, 5'b00000, 1'b1, 3'd0, 1'b1, 1'b0, 1'b0);
    tbl[3]  = mkv(1'b0, 5'b00000, 1'b1, 3'd1, 1'b0, 1'b0, 1'b0);
    tbl[4]  = mkv(1'b0, 5'b00000, 1'b1, 3'd2, 1'b0, 1'b0, 1'b0);
    tbl[5]  = mkv(1'b0, 5'b00000, 1'b1, 3'd2, 1'b1, 1'b0, 1'b0);
    tbl[6]  = mkv(1'b0, 5'b00000, 1'b1, 3'd3, 1'b0, 1'b0, 1'b0);
    tbl[7]  = mkv(1'b0, 5'b00000, 1'b1, 3'd4, 1'b0, 1'b1, 1'b1);
    tbl[8]  = mkv(1'b0, 5'b00000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    tbl[9]  = mkv(1'b1, 5'b00001, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);
    for (int s = 0; s < 5; s++)
      tbl[10 + s] = mkv(1'b0, 5'b00000, 1'b1, 3'(s), 1'b0, 1'b0, 1'b0);
    tbl[15] = mkv(1'b1, 5'b00000, 1'b1, 3'd4, 1'b1, 1'b1, 1'b1);
    for (int s = 0; s < 5; s++)
      tbl[16 + s] = mkv(1'b0, 5'b00000, 1'b1, 3'(s), 1'b0, s == 4, s == 4);
    tbl[21] = mkv(1'b0, 5'b00000, 1'b0, 3'd0, 1'b0, 1'b0, 1'b1);

    for (int i = 0; i < 22; i++) begin
      drive(tbl[i].fv, {tbl[i].flags, 123'd0}, 32'(i), 1'b0, 1'b1);
      #1;
      chk($sformatf("tbl%0d_valid", i), 128'(issue_fetch.valid), 128'(tbl[i].ev));
      chk($sformatf("tbl%0d_fetch_ready", i), 128'(fetch_ready), 128'(tbl[i].efr));
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_slot", i), 128'(slot_idx), 128'(tbl[i].es));
        chk($sformatf("tbl%0d_sub12", i), 128'(sub12), 128'(tbl[i].esub));
        chk($sformatf("tbl%0d_last", i), 128'(last), 128'(tbl[i].el));
      end
      @(negedge clk);
    end

    // Stall three cycles on slot 2.
    mcycle(1'b1, mkb(5'b00000), 32'h100, 1'b0, 1'b1);
    repeat (2) mcycle(1'b0, 128'd0, 32'd0, 1'b0, 1'b1);
    repeat (3) begin
      mcycle(1'b0, 128'd0, 32'd0, 1'b0, 1'b0);
      chk("stall_slot", 128'(slot_idx), 128'd2);
    end
    mcycle(1'b0, 128'd0, 32'd0, 1'b0, 1'b1);
    #1 chk("resume_slot", 128'(slot_idx), 128'd3);
    repeat (2) mcycle(1'b0, 128'd0, 32'd0, 1'b0, 1'b1);

    // Flush at slot 3 while a new bundle is on offer.
    mcycle(1'b1, mkb(5'b00000), 32'h200, 1'b0, 1'b1);
    repeat (3) mcycle(1'b0, 128'd0, 32'd0, 1'b0, 1'b1);
    mcycle(1'b1, mkb(5'b11111), 32'h300, 1'b1, 1'b1);
    mcycle(1'b1, mkb(5'b01010), 32'h400, 1'b0, 1'b1);
    repeat (7) mcycle(1'b0, 128'd0, 32'd0, 1'b0, 1'b1);

    // Asynchronous reset while on slot 2, second half.
    mcycle(1'b1, mkb(5'b10100), 32'h500, 1'b0, 1'b1);
    repeat (4) mcycle(1'b0, 128'd0, 32'd0, 1'b0, 1'b1);
    chk("pre_rst_slot", 128'(slot_idx), 128'd2);
    chk("pre_rst_sub12", 128'(sub12), 128'd1);
    rst_ni = 1'b0;
    #1;
    chk("arst_valid", 128'(issue_fetch.valid), 128'd0);
    chk("arst_slot", 128'(slot_idx), 128'd0);
    chk("arst_sub12", 128'(sub12), 128'd0);
    chk("arst_last", 128'(last), 128'd0);
    chk("arst_bundle", issue_fetch.bundle, 128'd0);
    m_valid = 1'b0;
    m_q.delete();
    @(negedge clk);
    rst_ni = 1'b1;
    mcycle(1'b1, mkb(5'b00110), 32'h600, 1'b0, 1'b1);
    mcycle(1'b0, 128'd0, 32'd0, 1'b0, 1'b1);

    // Random traffic.
    for (int i = 0; i < 500; i++) begin
      mcycle(1'($urandom_range(0, 1)), mkb(5'($urandom)), $urandom,
             ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
